// File: rtl/vga_pkg.sv
// Shared widths and 720p60 raster constants for the VGA timing generator.
// The *_720P values are the parameter defaults of vga_timing.
package vga_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;

  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  localparam int H_TOTAL_720P      = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
  localparam int V_TOTAL_720P      = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;
  localparam int H_SYNC_START_720P = H_ACTIVE_720P + H_FP_720P;
  localparam int H_SYNC_END_720P   = H_SYNC_START_720P + H_SYNC_720P;
  localparam int V_SYNC_START_720P = V_ACTIVE_720P + V_FP_720P;
  localparam int V_SYNC_END_720P   = V_SYNC_START_720P + V_SYNC_720P;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;

  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int sync_start(int active, int fp);
    return active + fp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Generic wrap counter for one raster axis with a registered sync-window decode.
// Reset parks the count on its last value so the first enabled edge lands on 0.
module vga_axis_counter #(
  parameter int W          = 11,
  parameter int TOTAL      = 1650,
  parameter int ACTIVE     = 1280,
  parameter int SYNC_START = 1390,
  parameter int SYNC_END   = 1430,
  parameter bit POL        = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         sync,
  output logic         wrap,
  output logic         act_nxt
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(SYNC_START);
  localparam logic [W-1:0] SYNC_HI = W'(SYNC_END);
  localparam logic [W-1:0] ACT_HI  = W'(ACTIVE);

  logic [W-1:0] cnt_q, cnt_d;
  logic         sync_q, sync_d;
  logic         in_win;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    // Decode from the next count so sync lines up with the count it belongs to.
    in_win  = (cnt_d >= SYNC_LO) && (cnt_d < SYNC_HI);
    sync_d  = in_win ? POL : ~POL;
    act_nxt = (cnt_d < ACT_HI);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= LAST;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;
  assign wrap = (cnt_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// Raster timing generator: x/y scan position, active qualifier, syncs and
// frame/line/vblank strobes, all registered, advancing on clk when en=1.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           hsync,
  output logic           vsync,
  output logic           frame_start,
  output logic           line_start,
  output logic           vblank_start
);

  localparam int H_TOTAL      = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL      = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SYNC_START = sync_start(H_ACTIVE, H_FP);
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = sync_start(V_ACTIVE, V_FP);
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam y_t V_LAST_ACTIVE = Y_W'(V_ACTIVE - 1);

  x_t   x_cnt;
  y_t   y_cnt;
  logic h_wrap, v_wrap;
  logic h_act_nxt, v_act_nxt;
  logic v_en;

  logic active_q, active_d;
  logic frame_start_q, frame_start_d;
  logic line_start_q, line_start_d;
  logic vblank_start_q, vblank_start_d;

  assign v_en = en & h_wrap;

  vga_axis_counter #(
    .W          (X_W),
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END),
    .POL        (HS_POL)
  ) u_h (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cnt     (x_cnt),
    .sync    (hsync),
    .wrap    (h_wrap),
    .act_nxt (h_act_nxt)
  );

  vga_axis_counter #(
    .W          (Y_W),
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END),
    .POL        (VS_POL)
  ) u_v (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (v_en),
    .cnt     (y_cnt),
    .sync    (vsync),
    .wrap    (v_wrap),
    .act_nxt (v_act_nxt)
  );

  // Strobes are pure functions of this edge, so they self-clear when en drops.
  always_comb begin
    active_d       = h_act_nxt & v_act_nxt;
    line_start_d   = v_en;
    frame_start_d  = v_en & v_wrap;
    vblank_start_d = v_en & (y_cnt == V_LAST_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q       <= 1'b0;
      frame_start_q  <= 1'b0;
      line_start_q   <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      active_q       <= active_d;
      frame_start_q  <= frame_start_d;
      line_start_q   <= line_start_d;
      vblank_start_q <= vblank_start_d;
    end
  end

  assign x            = x_cnt;
  assign y            = y_cnt;
  assign active       = active_q;
  assign frame_start  = frame_start_q;
  assign line_start   = line_start_q;
  assign vblank_start = vblank_start_q;

endmodule
